// File: rtl/usb_fifo_sched_pkg.sv
// Shared types and constants for the FX2 slave-FIFO write scheduler.
// Optional packet commit is enabled with the USB_SCHED_PKTEND_EN macro.
package usb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        XFER   = 2'd2,
        PKTEND = 2'd3
    } sched_state_e;

    localparam logic [1:0] FIFOADR_EP6 = 2'b10;
    localparam logic [1:0] FIFOADR_EP8 = 2'b11;

    localparam int MAX_BURST_LIMIT = 1024;
    localparam int BEAT_W          = $clog2(MAX_BURST_LIMIT + 1);

    // FIFOADR for a one-hot winner; requester 1 only when it alone holds the grant.
    function automatic logic [1:0] ep_addr_sel(input logic [1:0] gnt,
                                               input logic [1:0] a0,
                                               input logic [1:0] a1);
        return (gnt == 2'b10) ? a1 : a0;
    endfunction

endpackage

// File: rtl/usb_fifo_sched_if.sv
// Requester handshakes and FX2 slave-FIFO pins of the write scheduler.
interface usb_fifo_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       fifo_full_n;
    logic [7:0] fifo_data;
    logic       fifo_slwr_n;
    logic       fifo_pktend_n;
    logic [1:0] fifo_addr;
    logic [1:0] grant;

    modport slave (
        input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full_n,
        output req0_ready, req1_ready, fifo_data, fifo_slwr_n, fifo_pktend_n, fifo_addr, grant
    );

    modport master (
        output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full_n,
        input  req0_ready, req1_ready, fifo_data, fifo_slwr_n, fifo_pktend_n, fifo_addr, grant
    );
endinterface

// File: rtl/usb_fifo_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic [1:0] owner,
    output logic [1:0] gnt
);
    logic last_r;

    // Remember who was served last; reset as if requester 1 was, so requester 0 is favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (update) begin
            last_r <= (owner == 2'b10);
        end else begin
            last_r <= last_r;
        end
    end

    // One-hot winner selection.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/usb_fifo_sched.sv
// Arbitrates two byte streams onto an FX2 slave FIFO write port.
// Define USB_SCHED_PKTEND_EN to commit packets with a PKTEND strobe after a last byte.
module usb_fifo_sched
    import usb_sched_pkg::*;
#(
    parameter int         MAX_BURST = 512,
    parameter logic [1:0] EP_ADDR0  = FIFOADR_EP6,
    parameter logic [1:0] EP_ADDR1  = FIFOADR_EP8
) (
    input  logic            USB_CLKO,
    input  logic            USB_RESET2,
    usb_fifo_sched_if.slave bus
);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

    sched_state_e      state_r, state_s;
    logic [1:0]        grant_r, grant_s;
    logic [1:0]        addr_r, addr_s;
    logic [7:0]        data_r, data_s;
    logic              slwr_n_r, slwr_n_s;
    logic [BEAT_W-1:0] beat_r, beat_s;
    logic              pktend_n_s;
    logic              release_s;
    logic [1:0]        arb_gnt_s;
    logic              owner_valid_s, owner_last_s, can_take_s, hs_s;
    logic [7:0]        owner_data_s;

    rr_arb2 u_arb (
        .clk    (USB_CLKO),
        .rst    (USB_RESET2),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .update (release_s),
        .owner  (grant_r),
        .gnt    (arb_gnt_s)
    );

    assign owner_valid_s = (grant_r[0] & bus.req0_valid) | (grant_r[1] & bus.req1_valid);
    assign owner_data_s  = grant_r[1] ? bus.req1_data : bus.req0_data;
    assign owner_last_s  = grant_r[1] ? bus.req1_last : bus.req0_last;
    // Ready is withheld during reset so no byte is reported accepted and then dropped.
    assign can_take_s    = (state_r == XFER) & bus.fifo_full_n & (beat_r < BEAT_MAX) & ~USB_RESET2;
    assign hs_s          = can_take_s & owner_valid_s;

    assign bus.req0_ready = can_take_s & grant_r[0];
    assign bus.req1_ready = can_take_s & grant_r[1];
    assign bus.grant      = grant_r;
    assign bus.fifo_addr  = addr_r;
    assign bus.fifo_data  = data_r;
    assign bus.fifo_slwr_n = slwr_n_r;

    // Next-state and next-output decode.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        addr_s     = addr_r;
        data_s     = data_r;
        slwr_n_s   = 1'b1;
        beat_s     = beat_r;
        pktend_n_s = 1'b1;
        release_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_gnt_s != 2'b00) begin
                    grant_s = arb_gnt_s;
                    addr_s  = ep_addr_sel(arb_gnt_s, EP_ADDR0, EP_ADDR1);
                    beat_s  = '0;
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: state_s = XFER;
            XFER: begin
                if (!owner_valid_s) begin
                    state_s   = IDLE;
                    grant_s   = 2'b00;
                    release_s = 1'b1;
                end else if (hs_s) begin
                    data_s   = owner_data_s;
                    slwr_n_s = 1'b0;
                    beat_s   = beat_r + BEAT_W'(1);
                    if (owner_last_s) begin
`ifdef USB_SCHED_PKTEND_EN
                        state_s = PKTEND;
`else
                        state_s   = IDLE;
                        grant_s   = 2'b00;
                        release_s = 1'b1;
`endif
                    end else if ((beat_r + BEAT_W'(1)) >= BEAT_MAX) begin
                        state_s   = IDLE;
                        grant_s   = 2'b00;
                        release_s = 1'b1;
                    end else begin
                        state_s = XFER;
                    end
                end else begin
                    state_s = XFER;
                end
            end
            PKTEND: begin
                pktend_n_s = 1'b0;
                state_s    = IDLE;
                grant_s    = 2'b00;
                release_s  = 1'b1;
            end
            default: begin
                state_s = IDLE;
                grant_s = 2'b00;
            end
        endcase
    end

    // State and output registers; reset also drops any strobe decoded this cycle.
    always_ff @(posedge USB_CLKO) begin
        if (USB_RESET2) begin
            state_r  <= IDLE;
            grant_r  <= 2'b00;
            addr_r   <= EP_ADDR0;
            data_r   <= 8'h00;
            slwr_n_r <= 1'b1;
            beat_r   <= '0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            addr_r   <= addr_s;
            data_r   <= data_s;
            slwr_n_r <= slwr_n_s;
            beat_r   <= beat_s;
        end
    end

`ifdef USB_SCHED_PKTEND_EN
    logic pktend_n_r;

    // Packet-commit strobe register.
    always_ff @(posedge USB_CLKO) begin
        if (USB_RESET2) begin
            pktend_n_r <= 1'b1;
        end else begin
            pktend_n_r <= pktend_n_s;
        end
    end

    assign bus.fifo_pktend_n = pktend_n_r;
`else
    assign bus.fifo_pktend_n = 1'b1;
    logic unused_s;
    assign unused_s = pktend_n_s;
`endif
endmodule

// File: tb/tb_usb_fifo_sched.sv
// Directed bench for usb_fifo_sched: per-cycle vector table plus multi-cycle arbitration sequences.
module tb_usb_fifo_sched;

`ifdef USB_SCHED_PKTEND_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif
    localparam logic [1:0] G_PK0 = PK ? 2'b01 : 2'b00;
    localparam logic [1:0] G_PK1 = PK ? 2'b10 : 2'b00;
    localparam logic       P_PK  = PK ? 1'b0 : 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_fifo_sched_if bus ();

    usb_fifo_sched #(.MAX_BURST(8)) dut (
        .USB_CLKO   (clk),
        .USB_RESET2 (rst),
        .bus        (bus)
    );

    typedef struct {
        logic       rst, v0, l0, v1, l1, full;
        logic [7:0] d0, d1;
        logic [1:0] g, a;
        logic       s, r0, r1, p;
        logic [7:0] dt;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic v0, input logic [7:0] d0, input logic l0,
                                input logic v1, input logic [7:0] d1, input logic l1, input logic fl,
                                input logic [1:0] g, input logic [1:0] a, input logic s,
                                input logic [7:0] dt, input logic r0, input logic r1, input logic p);
        vec_t v;
        v.rst = rs; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.full = fl;
        v.g = g; v.a = a; v.s = s; v.dt = dt; v.r0 = r0; v.r1 = r1; v.p = p;
        return v;
    endfunction

    int errors = 0;
    int checks = 0;

    // requester models for the hand-written sequences
    int         en[2], base[2], plen[2], lim[2], cnt[2];
    logic       hsf[2];
    logic [7:0] expq[$];
    logic [1:0] glog[$];
    logic [1:0] gprev;
    int         strobes, pkt_pulses;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_last  = 1'b0; bus.req1_last  = 1'b0;
        bus.fifo_full_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; cnt[i] = 0; hsf[i] = 1'b0; plen[i] = 0; lim[i] = 0; base[i] = 0;
        end
        expq.delete(); glog.delete();
        gprev = 2'b00; strobes = 0; pkt_pulses = 0;
    endtask

    task automatic step();
        logic       v[2];
        logic       l[2];
        logic [7:0] d[2];
        logic [7:0] e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (hsf[i]) cnt[i]++;
            v[i] = (en[i] != 0) && (cnt[i] < lim[i]);
            d[i] = 8'(base[i] + cnt[i]);
            l[i] = (plen[i] != 0) && ((cnt[i] % plen[i]) == (plen[i] - 1));
        end
        bus.req0_valid = v[0]; bus.req0_data = d[0]; bus.req0_last = l[0];
        bus.req1_valid = v[1]; bus.req1_data = d[1]; bus.req1_last = l[1];
        #1;
        if (bus.fifo_slwr_n == 1'b0) begin
            strobes++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got data=%h expected no strobe", bus.fifo_data);
            end else begin
                e = expq.pop_front();
                if (bus.fifo_data !== e) begin
                    errors++;
                    $display("FAIL strobe_data got=%h expected=%h", bus.fifo_data, e);
                end
            end
        end
        if (bus.fifo_pktend_n == 1'b0) pkt_pulses++;
        checks++;
        if (((bus.req0_ready & ~bus.grant[0]) | (bus.req1_ready & ~bus.grant[1])) !== 1'b0) begin
            errors++;
            $display("FAIL nonowner_ready got rdy=%b%b grant=%b expected no ready outside owner",
                     bus.req1_ready, bus.req0_ready, bus.grant);
        end
        hsf[0] = v[0] & bus.req0_ready;
        hsf[1] = v[1] & bus.req1_ready;
        if (hsf[0]) expq.push_back(d[0]);
        if (hsf[1]) expq.push_back(d[1]);
        if (bus.grant != gprev && bus.grant != 2'b00) glog.push_back(bus.grant);
        gprev = bus.grant;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[28];
        logic [15:0] act, exp;
        int snap;
        bit  seen;

        vt[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        vt[1]  = mk(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        vt[2]  = mk(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        vt[3]  = mk(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        vt[4]  = mk(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b1);
        vt[5]  = mk(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1);
        vt[6]  = mk(1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 8'hA2, 1'b1, 1'b0, 1'b1);
        vt[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, G_PK0, 2'b10, 1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
        vt[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 8'hA3, 1'b0, 1'b0, P_PK);
        vt[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
        vt[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
        vt[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 2'b10, 2'b11, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
        vt[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 2'b10, 2'b11, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1);
        vt[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 8'hB0, 1'b0, 1'b0, 1'b1);
        for (int i = 14; i < 18; i++)
            vt[i] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 2'b10, 2'b11, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1);
        vt[18] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 2'b10, 2'b11, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1);
        vt[19] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 2'b10, 2'b11, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b1);
        vt[20] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, G_PK1, 2'b11, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b1);
        vt[21] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b11, 1'b1, 8'hB2, 1'b0, 1'b0, P_PK);
        vt[22] = mk(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b11, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
        vt[23] = mk(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
        vt[24] = mk(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1);
        vt[25] = mk(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1);
        vt[26] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        vt[27] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
        bus.fifo_full_n = 1'b1;
        repeat (2) @(posedge clk);

        // per-cycle table: packet A, stalled packet B, reset in the middle of C
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst = vt[i].rst;
            bus.req0_valid = vt[i].v0; bus.req0_data = vt[i].d0; bus.req0_last = vt[i].l0;
            bus.req1_valid = vt[i].v1; bus.req1_data = vt[i].d1; bus.req1_last = vt[i].l1;
            bus.fifo_full_n = vt[i].full;
            #1;
            act = {bus.grant, bus.fifo_addr, bus.fifo_slwr_n, bus.fifo_data,
                   bus.req0_ready, bus.req1_ready, bus.fifo_pktend_n};
            exp = {vt[i].g, vt[i].a, vt[i].s, vt[i].dt, vt[i].r0, vt[i].r1, vt[i].p};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d got={g,a,slwr,data,r0,r1,pkt}=%h expected=%h", i, act, exp);
            end
        end

        // both requesters always valid, 3-byte packets: grants must alternate
        model_reset();
        en[0] = 1; base[0] = 8'h10; plen[0] = 3; lim[0] = 6;
        en[1] = 1; base[1] = 8'h20; plen[1] = 3; lim[1] = 6;
        repeat (40) step();
        check_eq("alt_grant_count", glog.size() >= 4 ? 4 : glog.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < glog.size())
                check_eq($sformatf("alt_grant%0d", i), int'(glog[i]), (i % 2 == 0) ? 1 : 2);
        check_eq("alt_strobes", strobes, 12);
        check_eq("alt_bytes", cnt[0] + cnt[1], 12);
        check_eq("alt_pending", expq.size(), 0);
        check_eq("alt_pktend_pulses", pkt_pulses, PK ? 4 : 0);

        // req1 streams without last; burst limit of 8 hands over to waiting req0
        model_reset();
        en[1] = 1; base[1] = 8'h40; plen[1] = 0; lim[1] = 20;
        base[0] = 8'h50; plen[0] = 2; lim[0] = 2;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            seen = (bus.grant == 2'b10);
        end
        check_eq("burst_req1_granted", int'(seen), 1);
        en[0] = 1;
        snap = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (snap < 0 && bus.grant == 2'b01) snap = cnt[1];
        end
        check_eq("burst_req1_bytes_before_release", snap, 8);
        check_eq("burst_grant_order0", glog.size() > 0 ? int'(glog[0]) : 0, 2);
        check_eq("burst_grant_order1", glog.size() > 1 ? int'(glog[1]) : 0, 1);
        check_eq("burst_req0_bytes", cnt[0], 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
